// File: rtl/ps2_key_rx.sv
// ps2_key_rx: PS/2 keyboard deframer (clk, reset, ps2_clk, ps2_data -> ps2_key[10:0] toggle-strobed event, frame_err pulse); optional PS2_WATCHDOG_EN adds a mid-frame timeout abort
module ps2_key_rx #(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_nx;
  logic [1:0] clk_s, dat_s;
  logic [FILTER_LEN-1:0] flt;
  logic clk_f, fall, din, abort, stop_edge, frm_ok, bad, resp, pre;
  logic [7:0] sr;
  logic [2:0] cnt;
  logic par, ext, rel;
  assign din = dat_s[1];
  assign fall = clk_f & ~|flt;
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s <= '1;
      dat_s <= '1;
      flt <= '1;
      clk_f <= 1'b1;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_data};
      flt <= {flt[FILTER_LEN-2:0], clk_s[1]};
      clk_f <= &flt ? 1'b1 : ~|flt ? 1'b0 : clk_f;
    end
  end
`ifdef PS2_WATCHDOG_EN
  logic [15:0] wd;
  always_ff @(posedge clk) begin
    if (reset || fall || state == IDLE) wd <= '0;
    else if (wd != 16'hFFFF) wd <= wd + 16'd1;
  end
  assign abort = (state != IDLE) & ~fall & (wd == 16'(TIMEOUT));
`else
  assign abort = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    if (abort) state_nx = IDLE;
    else if (fall)
      state_nx = state == IDLE ? (din ? IDLE : DATA) :
                 state == DATA ? (cnt == 3'd7 ? PARITY : DATA) :
                 state == PARITY ? STOP : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      sr <= '0;
      par <= 1'b0;
    end else if (fall) begin
      cnt <= state == DATA ? cnt + 3'd1 : 3'd0;
      sr <= state == DATA ? {din, sr[7:1]} : sr;
      par <= state == PARITY ? din : par;
    end
  end
  assign stop_edge = fall & (state == STOP);
  assign frm_ok = din & ^{par, sr};
  assign bad = abort | (stop_edge & ~frm_ok);
  assign pre = (sr == 8'hE0) | (sr == 8'hF0);
  assign resp = (sr == 8'hAA) | (sr == 8'hFA) | (sr == 8'hFE) | (sr == 8'hEE) | (sr == 8'h00) | (sr == 8'hFF);
  always_ff @(posedge clk) begin
    if (reset) begin
      ps2_key <= '0;
      frame_err <= 1'b0;
      ext <= 1'b0;
      rel <= 1'b0;
    end else begin
      frame_err <= bad;
      ext <= bad ? 1'b0 : ~stop_edge ? ext : sr == 8'hE0 ? 1'b1 : (sr == 8'hF0 || resp) ? ext : 1'b0;
      rel <= bad ? 1'b0 : ~stop_edge ? rel : sr == 8'hF0 ? 1'b1 : (sr == 8'hE0 || resp) ? rel : 1'b0;
      ps2_key <= (stop_edge & frm_ok & ~pre & ~resp) ? {~ps2_key[10], ~rel, ext, sr} : ps2_key;
    end
  end
endmodule

// File: tb/tb_ps2_key_rx.sv
// tb_ps2_key_rx: randomized scoreboard bench for ps2_key_rx
module tb_ps2_key_rx;
  logic clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic frame_err;
  int checks = 0, errors = 0;
  int half = 15;
  typedef struct {bit err; logic [10:0] key;} ev_t;
  ev_t exp_q[$];
  logic [10:0] ref_key = '0;
  bit ref_ext = 0, ref_rel = 0;
  logic [10:0] last_key = '0;
  bit last_err = 0;
  logic [7:0] resp_tab [6] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
  ps2_key_rx dut (.clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .ps2_key(ps2_key), .frame_err(frame_err));
  always #5 clk = ~clk;
  task automatic ticks(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic bit_out(bit v);
    ps2_data = v;
    ticks(half);
    ps2_clk = 1'b0;
    ticks(half);
    ps2_clk = 1'b1;
  endtask
  task automatic model(logic [7:0] b, bit ok);
    ev_t e;
    if (!ok) begin
      e.err = 1; e.key = ref_key; exp_q.push_back(e);
      ref_ext = 0; ref_rel = 0;
    end else if (b == 8'hE0) ref_ext = 1;
    else if (b == 8'hF0) ref_rel = 1;
    else if (!(b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) begin
      ref_key = {~ref_key[10], ~ref_rel, ref_ext, b};
      e.err = 0; e.key = ref_key; exp_q.push_back(e);
      ref_ext = 0; ref_rel = 0;
    end
  endtask
  task automatic send(logic [7:0] b, bit bad_par = 0, bit bad_stop = 0);
    model(b, !bad_par && !bad_stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(~^b ^ bad_par);
    bit_out(!bad_stop);
    ps2_data = 1'b1;
    ticks(half * 2);
  endtask
  task automatic chk_key(string name, logic [10:0] k);
    checks++;
    if (ps2_key !== k) begin
      errors++;
      $display("FAIL %s ps2_key=%h required %h", name, ps2_key, k);
    end
  endtask
  task automatic pop_ev(bit err, logic [10:0] key);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event err=%0d key=%h required no event", err, key);
    end else begin
      e = exp_q.pop_front();
      if (e.err != err || (!err && e.key !== key)) begin
        errors++;
        $display("FAIL event err=%0d key=%h required err=%0d key=%h", err, key, e.err, e.key);
      end
    end
  endtask
  always @(negedge clk) begin
    if (frame_err) begin
      checks++;
      if (last_err) begin
        errors++;
        $display("FAIL err_width frame_err high 2+ cycles required 1");
      end else pop_ev(1, ps2_key);
    end
    if (ps2_key !== last_key) pop_ev(0, ps2_key);
    last_key = ps2_key;
    last_err = frame_err;
  end
  initial begin
    logic [7:0] b;
    ticks(3);
    reset = 1'b0;
    ticks(2);
    chk_key("reset_key", 11'h000);
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err frame_err=%b required 0", frame_err);
    end
    send(8'h1C); chk_key("t1_make", 11'h61C);
    send(8'hF0); chk_key("t2_f0_only", 11'h61C);
    send(8'h1C); chk_key("t2_break", 11'h01C);
    send(8'hE0); send(8'h75); chk_key("t3_ext_make", 11'h775);
    send(8'hE0); send(8'hF0); send(8'h75); chk_key("t3_ext_break", 11'h175);
    send(8'h1C, 1); chk_key("t4_bad_par", 11'h175);
    send(8'h1C); chk_key("t4_recover", 11'h61C);
    send(8'h1C, 0, 1); chk_key("bad_stop", 11'h61C);
    ps2_clk = 1'b0; ticks(2); ps2_clk = 1'b1; ticks(20);
    ps2_clk = 1'b0; ticks(3); ps2_clk = 1'b1; ticks(20);
    chk_key("t5_glitch", 11'h61C);
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(1'b1);
    reset = 1'b1;
    if (ref_key != 0) begin
      ev_t e;
      e.err = 0; e.key = '0; exp_q.push_back(e);
    end
    ref_key = '0; ref_ext = 0; ref_rel = 0;
    ticks(2);
    reset = 1'b0;
    ps2_data = 1'b1;
    ticks(10);
    chk_key("t5_reset", 11'h000);
    send(8'h1C); chk_key("t5_after_reset", 11'h61C);
`ifdef PS2_WATCHDOG_EN
    begin
      int n;
      bit_out(1'b0);
      for (int i = 0; i < 2; i++) bit_out(1'b1);
      ps2_data = 1'b0;
      ticks(half);
      model(8'h00, 0);
      ps2_clk = 1'b0;
      n = 0;
      while (!frame_err && n < 1300) begin
        @(negedge clk);
        n++;
        if (n == half) ps2_clk = 1'b1;
      end
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      checks++;
      if (n < 1000 || n > 1012) begin
        errors++;
        $display("FAIL watchdog_delay cycles=%0d required 1000..1012", n);
      end
      ticks(5);
      send(8'h29);
    end
`endif
    for (int k = 0; k < 60; k++) begin
      half = $urandom_range(6, 30);
      case ($urandom_range(0, 5))
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = resp_tab[$urandom_range(0, 5)];
        default: b = 8'($urandom_range(0, 255));
      endcase
      send(b, $urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0);
    end
    ticks(50);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events pending=%0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
